// File: rtl/uart_program_loader_if.sv
// -----------------------------------------------------------------------------
// uart_program_loader_if
//   Bundles the byte-receive strobe, the instruction-memory write port and
//   the load status of uart_program_loader.
//
//   Handshake semantics: rx_valid is a one-cycle strobe qualifying rx_data.
//   There is no ready/backpressure; the loader accepts or ignores every byte
//   on the cycle it is presented. wr_en is likewise a one-cycle strobe
//   qualifying wr_addr/wr_data; the memory must accept it unconditionally.
//
//   Modports:
//     master : the loader (consumes rx_*, drives wr_*, status, state_dbg)
//     slave  : the environment (drives rx_*, observes everything else)
//
//   state_dbg exposes the loader FSM encoding for observation only.
// -----------------------------------------------------------------------------
interface uart_program_loader_if #(
  parameter int ADDR_W = 5
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              load_done;
  logic              load_error;
  logic [2:0]        state_dbg;

  modport master (
    input  rx_valid, rx_data,
    output wr_en, wr_addr, wr_data, load_done, load_error, state_dbg
  );

  modport slave (
    output rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data, load_done, load_error, state_dbg
  );
endinterface

// File: rtl/uart_program_loader.sv
// -----------------------------------------------------------------------------
// uart_program_loader
//   Framed program loader between a UART byte receiver and instruction memory.
//   Frame: SYNC_BYTE, word count N (1..DEPTH), N big-endian 16-bit words,
//   checksum byte C such that (N + all payload bytes + C) mod 256 == 0.
//
//   Ports:
//     CLK    : system clock
//     RST_N  : asynchronous active-low reset
//     bus    : uart_program_loader_if.master
//              rx_valid/rx_data  byte strobe from the receiver
//              wr_en/wr_addr/wr_data  one-cycle instruction write port
//              load_done   sticky, program loaded with good checksum
//              load_error  last frame failed (count, checksum, timeout)
//              state_dbg   current FSM state
//
//   Optional feature (macro LOADER_ZERO_FILL_EN): after a good checksum with
//   N < DEPTH, the remaining addresses N..DEPTH-1 are written with 16'h0000,
//   one per cycle, before load_done asserts.
// -----------------------------------------------------------------------------
module uart_program_loader #(
  parameter int          ADDR_W         = 5,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  uart_program_loader_if.master  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Index is one bit wider than the address so count == DEPTH terminates.
  localparam int IW    = ADDR_W + 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5
`ifdef LOADER_ZERO_FILL_EN
    , FILL  = 3'd6
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        acc_q, acc_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;

  logic [7:0]        sum;
  logic              in_frame;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    hi_d         = hi_q;
    acc_d        = acc_q;
    tmo_d        = '0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;

    sum      = acc_q + bus.rx_data;
    in_frame = (state_q == COUNT) || (state_q == DATA_HI) ||
               (state_q == DATA_LO) || (state_q == CHECK);

    // Inter-byte timeout. A byte on the firing cycle wins: the timeout
    // branch only runs when rx_valid is low, and tmo_d defaults to 0.
    if (in_frame && !bus.rx_valid) begin
      if (tmo_q == TMO_LIMIT) begin
        load_error_d = 1'b1;
        state_d      = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          state_d      = COUNT;
          load_error_d = 1'b0;
          acc_d        = '0;
          idx_d        = '0;
          wr_addr_d    = '0;
        end
      end
      COUNT: begin
        if (bus.rx_valid) begin
          if ((bus.rx_data != 8'd0) && (int'(bus.rx_data) <= DEPTH)) begin
            cnt_d   = IW'(bus.rx_data);
            acc_d   = bus.rx_data;
            state_d = DATA_HI;
          end else begin
            load_error_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      DATA_HI: begin
        if (bus.rx_valid) begin
          hi_d    = bus.rx_data;
          acc_d   = sum;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (bus.rx_valid) begin
          acc_d     = sum;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = {hi_q, bus.rx_data};
          idx_d     = idx_q + IW'(1);
          state_d   = ((idx_q + IW'(1)) == cnt_q) ? CHECK : DATA_HI;
        end
      end
      CHECK: begin
        if (bus.rx_valid) begin
          if (sum == 8'd0) begin
`ifdef LOADER_ZERO_FILL_EN
            if (idx_q < IW'(DEPTH)) begin
              state_d = FILL;
            end else begin
              state_d     = DONE;
              load_done_d = 1'b1;
            end
`else
            state_d     = DONE;
            load_done_d = 1'b1;
`endif
          end else begin
            load_error_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
`ifdef LOADER_ZERO_FILL_EN
      FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q[ADDR_W-1:0];
        wr_data_d = 16'h0000;
        idx_d     = idx_q + IW'(1);
        // load_done is raised from DONE, one cycle after the last fill write.
        if (idx_q == IW'(DEPTH - 1)) state_d = DONE;
      end
`endif
      DONE: begin
        load_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      hi_q         <= '0;
      acc_q        <= '0;
      tmo_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      hi_q         <= hi_d;
      acc_q        <= acc_d;
      tmo_q        <= tmo_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_error = load_error_q;
  assign bus.state_dbg  = state_q;

endmodule
